// File: rtl/hilo_muldiv.sv
// Iterative signed multiply/divide unit that owns the HI/LO special registers.
// One shift-add or restoring-division step per cycle, then sign fix-up and write-back.
module hilo_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_div,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             readhilo,
    input  logic             spra,
    output logic [WIDTH-1:0] hilo_rd,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t               state, state_next;
    logic [CW-1:0]        cnt;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic                 sign_a, sign_b, op_div_q;
    logic [2*WIDTH-1:0]   acc, acc_next;
    logic [WIDTH-1:0]     hi, lo, hi_fix, lo_fix;

    logic [WIDTH:0]       mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0]   prod_signed;
    logic [WIDTH-1:0]     quo, rem, a_signed;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every output of this block is given a default first, so no path
    // through the case statement can leave a signal unassigned and infer a latch.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: if (start) state_next = CALC;
            CALC: begin
                busy = 1'b1;
                if (cnt == LAST_ITER) state_next = FIX;
            end
            FIX: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Single iteration step. acc holds {partial product, multiplier} for MULT
    // and {remainder, dividend/quotient} for DIV; both shift one bit per cycle.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? a_mag : '0)};
        div_shift = acc[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, b_mag};
        if (op_div_q) begin
            if (!div_diff[WIDTH]) acc_next = {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};
            else                  acc_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    // Sign correction and division special cases, consumed in FIX.
    always_comb begin
        prod_signed = (sign_a ^ sign_b) ? -acc : acc;
        quo         = acc[WIDTH-1:0];
        rem         = acc[2*WIDTH-1:WIDTH];
        a_signed    = sign_a ? -a_mag : a_mag;
        hi_fix      = prod_signed[2*WIDTH-1:WIDTH];
        lo_fix      = prod_signed[WIDTH-1:0];
        if (op_div_q) begin
            if (b_mag == '0) begin
                hi_fix = a_signed;
                lo_fix = '1;
            end else if (sign_a && a_mag == MIN_NEG && sign_b && b_mag == ONE) begin
                hi_fix = '0;
                lo_fix = MIN_NEG;
            end else begin
                hi_fix = sign_a ? -rem : rem;
                lo_fix = (sign_a ^ sign_b) ? -quo : quo;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            a_mag    <= '0;
            b_mag    <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            op_div_q <= 1'b0;
            acc      <= '0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    sign_a   <= srca[WIDTH-1];
                    sign_b   <= srcb[WIDTH-1];
                    a_mag    <= srca[WIDTH-1] ? -srca : srca;
                    b_mag    <= srcb[WIDTH-1] ? -srcb : srcb;
                    op_div_q <= op_div;
                    cnt      <= '0;
                    // Multiplier or dividend enters the low half; the high half starts clear.
                    acc      <= {{WIDTH{1'b0}}, (op_div ? (srca[WIDTH-1] ? -srca : srca)
                                                        : (srcb[WIDTH-1] ? -srcb : srcb))};
                end
                CALC: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    hi <= hi_fix;
                    lo <= lo_fix;
                end
                default: ;
            endcase
        end
    end

    assign hilo_rd = readhilo ? (spra ? hi : lo) : '0;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed bench for hilo_muldiv: a vector table of MULT/DIV cases plus
// hand-written sequences for ignored start pulses and mid-operation reset.
module tb_hilo_muldiv;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         op_div = 1'b0;
    logic [W-1:0] srca = '0;
    logic [W-1:0] srcb = '0;
    logic         readhilo = 1'b0;
    logic         spra = 1'b0;
    logic [W-1:0] hilo_rd;
    logic         busy;
    logic         done;

    int tests = 0;
    int failures = 0;

    hilo_muldiv #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op_div(op_div),
        .srca(srca), .srcb(srcb), .readhilo(readhilo), .spra(spra),
        .hilo_rd(hilo_rd), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic read_hilo(output logic [W-1:0] hi_v, output logic [W-1:0] lo_v);
        readhilo = 1'b1;
        spra = 1'b1;
        #1 hi_v = hilo_rd;
        spra = 1'b0;
        #1 lo_v = hilo_rd;
        readhilo = 1'b0;
    endtask

    task automatic check_hilo(input string name, input logic [W-1:0] ehi, input logic [W-1:0] elo);
        logic [W-1:0] h, l;
        read_hilo(h, l);
        check({name, "_hi"}, h, ehi);
        check({name, "_lo"}, l, elo);
    endtask

    // Start an operation, scramble operands after E0, and measure done latency.
    task automatic run_op(input string name, input logic op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo);
        int lat;
        @(negedge clk);
        start = 1'b1; op_div = op; srca = a; srcb = b;
        @(posedge clk);
        #1 start = 1'b0;
        srca = $urandom; srcb = $urandom; op_div = ~op;
        check({name, "_busy_rise"}, W'(busy), W'(1));
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
        check({name, "_latency"}, W'(lat), W'(W + 1));
        check({name, "_busy_in_done"}, W'(busy), W'(0));
        @(posedge clk);
        #1 check({name, "_done_width"}, W'(done), W'(0));
        check_hilo(name, ehi, elo);
    endtask

    initial begin
        int dones;
        logic [W-1:0] h, l;

        vecs[0] = '{1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[1] = '{1'b1, 32'd100,      32'd7,        32'd2,        32'd14};
        vecs[2] = '{1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{1'b1, 32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF};
        vecs[4] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5] = '{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[6] = '{1'b1, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
        vecs[7] = '{1'b1, 32'hFFFFFF9C, 32'd0,        32'hFFFFFF9C, 32'hFFFFFFFF};

        #12;
        check("reset_busy", W'(busy), W'(0));
        check("reset_done", W'(done), W'(0));
        check_hilo("reset", '0, '0);
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
        end

        // Read port gated off by readhilo even when HI holds a nonzero value.
        spra = 1'b1; readhilo = 1'b0;
        #1 check("readhilo_off", hilo_rd, '0);

        // A second start mid-MULT must be ignored.
        @(negedge clk);
        start = 1'b1; op_div = 1'b0; srca = 32'd5; srcb = 32'd6;
        @(posedge clk);
        #1 start = 1'b0;
        dones = 0;
        for (int c = 1; c <= 50; c++) begin
            if (c == 10) begin
                @(negedge clk);
                start = 1'b1; op_div = 1'b1; srca = 32'd99; srcb = 32'd3;
            end
            @(posedge clk);
            #1 start = 1'b0;
            if (done) dones++;
        end
        check("restart_done_count", W'(dones), W'(1));
        check_hilo("restart", 32'd0, 32'd30);

        // Reset in the middle of a DIV discards it and clears HI/LO at once.
        @(negedge clk);
        start = 1'b1; op_div = 1'b1; srca = 32'd100; srcb = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (14) @(posedge clk);
        #2 reset = 1'b0;
        #1 check("midreset_busy", W'(busy), W'(0));
        check("midreset_done", W'(done), W'(0));
        check_hilo("midreset", '0, '0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1 if (done) dones++;
        end
        check("midreset_no_done", W'(dones), W'(0));
        check_hilo("post_reset_idle", '0, '0);
        run_op("post_reset_mult", 1'b0, 32'd3, 32'd4, 32'd0, 32'd12);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
